// File: rtl/motor_pwm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pwm_ctrl_if
//  Description : Control and bridge-pin bundle for motor_pwm_ctrl.
//                The motion logic drives en/brake/load/duty_set/dir_set and
//                receives the per-channel bridge pins, at_target and the
//                period tick.
//  Ports (signals):
//      en          global enable, 0 = coast all channels
//      brake       global level-sensitive brake
//      load        1-cycle strobe capturing duty_set/dir_set as targets
//      duty_set    N_CH x CNT_W target duties, ch i at [i*CNT_W +: CNT_W]
//      dir_set     N_CH target directions (0 fwd, 1 rev)
//      pwm_out     N_CH bridge enable lines
//      in_a/in_b   N_CH bridge direction inputs
//      at_target   N_CH applied duty/dir equal target
//      period_tick one cycle per PWM period
//  Revision    : 1.0 - initial release
// ============================================================================
interface motor_pwm_ctrl_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 21
);
    logic                    en;
    logic                    brake;
    logic                    load;
    logic [N_CH*CNT_W-1:0]   duty_set;
    logic [N_CH-1:0]         dir_set;
    logic [N_CH-1:0]         pwm_out;
    logic [N_CH-1:0]         in_a;
    logic [N_CH-1:0]         in_b;
    logic [N_CH-1:0]         at_target;
    logic                    period_tick;

    // Motion-logic side
    modport master (
        output en, brake, load, duty_set, dir_set,
        input  pwm_out, in_a, in_b, at_target, period_tick
    );

    // Controller side
    modport slave (
        input  en, brake, load, duty_set, dir_set,
        output pwm_out, in_a, in_b, at_target, period_tick
    );
endinterface
`default_nettype wire

// File: rtl/motor_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pwm_ctrl
//  Description : N-channel H-bridge (L298-style) controller. One shared
//                period counter drives a PWM enable per channel; each
//                channel ramps its applied duty toward a loaded target by
//                at most RAMP_STEP per period, reverses only through zero
//                duty, and supports a global coast (en=0) and brake.
//  Ports:
//      clk          system clock
//      rst          synchronous active-high reset
//      bus (slave)  en, brake, load, duty_set, dir_set in;
//                   pwm_out, in_a, in_b, at_target, period_tick out
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_ctrl #(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 21,
    parameter int PERIOD    = 1450000,
    parameter int RAMP_STEP = 50000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    motor_pwm_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    // One extra bit so cur+STEP can never wrap.
    localparam logic [CNT_W:0]   C_STEP   = (CNT_W + 1)'(RAMP_STEP);

    // ------------------------------------------------------------------
    // Shared period counter and tick
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_tick_q, period_tick_d;
    logic             w_boundary;
    logic             w_inhibit;
    logic             w_load_ok;

    always_comb begin
        w_boundary    = (cnt_q == C_LAST);
        // Coast and brake both hold the applied duty at zero so that a
        // release always restarts the ramp from standstill.
        w_inhibit     = ~bus.en | bus.brake;
        // An active brake masks target updates.
        w_load_ok     = bus.load & ~(bus.en & bus.brake);
        cnt_d         = w_boundary ? '0 : cnt_q + C_ONE;
        period_tick_d = w_boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            period_tick_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            period_tick_q <= period_tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel target capture, ramp and pin generation
    // ------------------------------------------------------------------
    logic [N_CH-1:0] w_pwm;
    logic [N_CH-1:0] w_in_a;
    logic [N_CH-1:0] w_in_b;
    logic [N_CH-1:0] w_at_target;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] tgt_duty_q, tgt_duty_d;
        logic [CNT_W-1:0] cur_duty_q, cur_duty_d;
        logic             tgt_dir_q,  tgt_dir_d;
        logic             cur_dir_q,  cur_dir_d;
        logic             pwm_q,      pwm_d;
        logic             in_a_q,     in_a_d;
        logic             in_b_q,     in_b_d;
        logic             at_target_q, at_target_d;

        logic [CNT_W-1:0] w_duty_req;
        logic [CNT_W:0]   w_cur_ext;
        logic [CNT_W:0]   w_tgt_ext;
        logic [CNT_W:0]   w_up;
        logic [CNT_W:0]   w_down;

        always_comb begin
            w_duty_req = bus.duty_set[i*CNT_W +: CNT_W];
            w_cur_ext  = {1'b0, cur_duty_q};
            w_tgt_ext  = {1'b0, tgt_duty_q};
            w_up       = w_cur_ext + C_STEP;
            w_down     = (w_cur_ext > C_STEP) ? (w_cur_ext - C_STEP) : '0;

            // Targets: duty is clamped to a full period on capture.
            tgt_duty_d = tgt_duty_q;
            tgt_dir_d  = tgt_dir_q;
            if (w_load_ok) begin
                tgt_duty_d = (w_duty_req > C_PERIOD) ? C_PERIOD : w_duty_req;
                tgt_dir_d  = bus.dir_set[i];
            end

            // Ramp at the period boundary. The *_q targets are used, so a
            // load landing on the boundary cycle takes effect one period
            // later.
            cur_duty_d = cur_duty_q;
            cur_dir_d  = cur_dir_q;
            if (w_boundary) begin
                if (RAMP_STEP == 0) begin
                    cur_duty_d = tgt_duty_q;
                    cur_dir_d  = tgt_dir_q;
                end else if (cur_dir_q != tgt_dir_q) begin
                    // Reverse only through zero: first ramp down, then flip
                    // the direction during a full zero-duty period.
                    if (cur_duty_q != '0) begin
                        cur_duty_d = w_down[CNT_W-1:0];
                    end else begin
                        cur_dir_d = tgt_dir_q;
                    end
                end else if (w_cur_ext < w_tgt_ext) begin
                    cur_duty_d = (w_up > w_tgt_ext) ? tgt_duty_q : w_up[CNT_W-1:0];
                end else if (w_cur_ext > w_tgt_ext) begin
                    cur_duty_d = (w_down < w_tgt_ext) ? tgt_duty_q : w_down[CNT_W-1:0];
                end
            end
            if (w_inhibit) begin
                cur_duty_d = '0;
            end

            // Pins: coast (all low) beats brake (all high) beats drive.
            pwm_d  = 1'b0;
            in_a_d = 1'b0;
            in_b_d = 1'b0;
            if (bus.en) begin
                if (bus.brake) begin
                    pwm_d  = 1'b1;
                    in_a_d = 1'b1;
                    in_b_d = 1'b1;
                end else begin
                    pwm_d  = (cnt_q < cur_duty_q);
                    in_a_d = ~cur_dir_q;
                    in_b_d = cur_dir_q;
                end
            end

            at_target_d = (cur_duty_q == tgt_duty_q) && (cur_dir_q == tgt_dir_q);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                tgt_duty_q  <= '0;
                cur_duty_q  <= '0;
                tgt_dir_q   <= 1'b0;
                cur_dir_q   <= 1'b0;
                pwm_q       <= 1'b0;
                in_a_q      <= 1'b0;
                in_b_q      <= 1'b0;
                at_target_q <= 1'b0;
            end else begin
                tgt_duty_q  <= tgt_duty_d;
                cur_duty_q  <= cur_duty_d;
                tgt_dir_q   <= tgt_dir_d;
                cur_dir_q   <= cur_dir_d;
                pwm_q       <= pwm_d;
                in_a_q      <= in_a_d;
                in_b_q      <= in_b_d;
                at_target_q <= at_target_d;
            end
        end

        assign w_pwm[i]       = pwm_q;
        assign w_in_a[i]      = in_a_q;
        assign w_in_b[i]      = in_b_q;
        assign w_at_target[i] = at_target_q;
    end

    assign bus.pwm_out     = w_pwm;
    assign bus.in_a        = w_in_a;
    assign bus.in_b        = w_in_b;
    assign bus.at_target   = w_at_target;
    assign bus.period_tick = period_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_pwm_ctrl
//  Description : Self-checking bench for motor_pwm_ctrl with PERIOD=10,
//                RAMP_STEP=3, CNT_W=5, N_CH=2. An integer-level model of the
//                channel rules is compared against the pins every cycle;
//                directed scenarios add hand-computed per-period pulse
//                counts and pin values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_ctrl;

    localparam int N_CH      = 2;
    localparam int CNT_W     = 5;
    localparam int PERIOD    = 10;
    localparam int RAMP_STEP = 3;

    logic clk;
    logic rst;

    motor_pwm_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    motor_pwm_ctrl #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .PERIOD   (PERIOD),
        .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: integer duties, updated once per clock from the rules.
    // ------------------------------------------------------------------
    int          m_cnt = 0;
    int          m_cur  [N_CH];
    int          m_tgt  [N_CH];
    bit          m_cdir [N_CH];
    bit          m_tdir [N_CH];
    logic [N_CH-1:0] e_pwm = '0, e_ina = '0, e_inb = '0, e_at = '0;
    logic            e_tick = 1'b0;

    initial begin
        for (int c = 0; c < N_CH; c++) begin
            m_cur[c] = 0; m_tgt[c] = 0; m_cdir[c] = 0; m_tdir[c] = 0;
        end
    end

    always @(posedge clk) begin : p_model
        int cur_n;
        int tgt_n;
        int req;
        bit cdir_n;
        bit tdir_n;
        if (rst) begin
            m_cnt  <= 0;
            e_pwm  <= '0; e_ina <= '0; e_inb <= '0; e_at <= '0; e_tick <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                m_cur[c] <= 0; m_tgt[c] <= 0; m_cdir[c] <= 0; m_tdir[c] <= 0;
            end
        end else begin
            e_tick <= (m_cnt == PERIOD - 1);
            for (int c = 0; c < N_CH; c++) begin
                if (!bus.en) begin
                    e_pwm[c] <= 1'b0; e_ina[c] <= 1'b0; e_inb[c] <= 1'b0;
                end else if (bus.brake) begin
                    e_pwm[c] <= 1'b1; e_ina[c] <= 1'b1; e_inb[c] <= 1'b1;
                end else begin
                    e_pwm[c] <= (m_cnt < m_cur[c]);
                    e_ina[c] <= !m_cdir[c];
                    e_inb[c] <= m_cdir[c];
                end
                e_at[c] <= (m_cur[c] == m_tgt[c]) && (m_cdir[c] == m_tdir[c]);

                cur_n = m_cur[c]; cdir_n = m_cdir[c];
                tgt_n = m_tgt[c]; tdir_n = m_tdir[c];
                if (m_cnt == PERIOD - 1) begin
                    if (m_cdir[c] != m_tdir[c]) begin
                        if (m_cur[c] > 0) cur_n = (m_cur[c] > RAMP_STEP) ? m_cur[c] - RAMP_STEP : 0;
                        else              cdir_n = m_tdir[c];
                    end else if (m_cur[c] < m_tgt[c]) begin
                        cur_n = (m_cur[c] + RAMP_STEP > m_tgt[c]) ? m_tgt[c] : m_cur[c] + RAMP_STEP;
                    end else begin
                        cur_n = (m_cur[c] - RAMP_STEP < m_tgt[c]) ? m_tgt[c] : m_cur[c] - RAMP_STEP;
                    end
                end
                if (!bus.en || bus.brake) cur_n = 0;
                if (bus.load && !(bus.en && bus.brake)) begin
                    req    = int'(bus.duty_set[c*CNT_W +: CNT_W]);
                    tgt_n  = (req > PERIOD) ? PERIOD : req;
                    tdir_n = bus.dir_set[c];
                end
                m_cur[c] <= cur_n; m_cdir[c] <= cdir_n;
                m_tgt[c] <= tgt_n; m_tdir[c] <= tdir_n;
            end
            m_cnt <= (m_cnt + 1) % PERIOD;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("pwm_out",     32'(bus.pwm_out),     32'(e_pwm));
        check("in_a",        32'(bus.in_a),        32'(e_ina));
        check("in_b",        32'(bus.in_b),        32'(e_inb));
        check("at_target",   32'(bus.at_target),   32'(e_at));
        check("period_tick", 32'(bus.period_tick), 32'(e_tick));
    end

    // ------------------------------------------------------------------
    // Directed helpers (all run on negedges)
    // ------------------------------------------------------------------
    task automatic sync_tick(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.period_tick !== 1'b1 && k < 3*PERIOD);
        if (bus.period_tick !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: period_tick got 0 expected 1 within %0d cycles", name, 3*PERIOD);
        end
    endtask

    // Called on a tick negedge: counts the high cycles of the period that
    // just started and ends on the next tick negedge.
    task automatic period_chk(input string name, input int e0, input int e1);
        int c0;
        int c1;
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            if (bus.pwm_out[0] === 1'b1) c0++;
            if (bus.pwm_out[1] === 1'b1) c1++;
        end
        check($sformatf("%s ch0 high cycles", name), 32'(c0), 32'(e0));
        check($sformatf("%s ch1 high cycles", name), 32'(c1), 32'(e1));
    endtask

    task automatic do_load(input int d0, input int d1, input logic [1:0] dir);
        bus.duty_set = {CNT_W'(d1), CNT_W'(d0)};
        bus.dir_set  = dir;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int ticks;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.brake    = 1'b0;
        bus.load     = 1'b0;
        bus.duty_set = '0;
        bus.dir_set  = '0;
        repeat (3) @(negedge clk);
        check("reset pwm_out",   32'(bus.pwm_out),   32'h0);
        check("reset at_target", 32'(bus.at_target), 32'h0);
        rst    = 1'b0;
        bus.en = 1'b1;
        @(negedge clk);
        check("post-reset at_target", 32'(bus.at_target), 32'h3);

        // 1: ch0 soft start to 7 forward
        sync_tick("t1 align");
        do_load(7, 0, 2'b00);
        sync_tick("t1 ramp");
        period_chk("t1 p1", 3, 0);
        period_chk("t1 p2", 6, 0);
        check("t1 at_target0 before settle", 32'(bus.at_target[0]), 32'h0);
        period_chk("t1 p3", 7, 0);
        check("t1 at_target0 settled", 32'(bus.at_target[0]), 32'h1);
        period_chk("t1 p4", 7, 0);
        check("t1 in_a0", 32'(bus.in_a[0]), 32'h1);
        check("t1 in_b0", 32'(bus.in_b[0]), 32'h0);

        // 2: ch1 duty 15 clamps to full period
        do_load(7, 15, 2'b00);
        sync_tick("t2 ramp");
        period_chk("t2 p1", 7, 3);
        period_chk("t2 p2", 7, 6);
        period_chk("t2 p3", 7, 9);
        period_chk("t2 p4", 7, 10);
        period_chk("t2 p5", 7, 10);
        check("t2 at_target", 32'(bus.at_target), 32'h3);

        // 3: ch0 reversal through zero
        do_load(7, 15, 2'b01);
        sync_tick("t3 ramp");
        period_chk("t3 p1", 4, 10);
        period_chk("t3 p2", 1, 10);
        period_chk("t3 p3", 0, 10);
        check("t3 in_a0 before flip", 32'(bus.in_a[0]), 32'h1);
        period_chk("t3 p4", 0, 10);
        check("t3 in_a0 after flip", 32'(bus.in_a[0]), 32'h0);
        check("t3 in_b0 after flip", 32'(bus.in_b[0]), 32'h1);
        period_chk("t3 p5", 3, 10);
        period_chk("t3 p6", 6, 10);
        period_chk("t3 p7", 7, 10);

        // 4: brake mid-period, then ramp restarts from zero
        repeat (4) @(negedge clk);
        bus.brake = 1'b1;
        @(negedge clk);
        check("t4 brake pwm", 32'(bus.pwm_out), 32'h3);
        check("t4 brake in_a", 32'(bus.in_a), 32'h3);
        check("t4 brake in_b", 32'(bus.in_b), 32'h3);
        repeat (11) @(negedge clk);
        bus.brake = 1'b0;
        sync_tick("t4 release");
        period_chk("t4 p1", 3, 3);

        // 5: coast mid-pulse; counter keeps running
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        check("t5 coast pwm", 32'(bus.pwm_out), 32'h0);
        check("t5 coast in_a", 32'(bus.in_a), 32'h0);
        check("t5 coast in_b", 32'(bus.in_b), 32'h0);
        ticks = 0;
        for (int k = 0; k < 3*PERIOD; k++) begin
            @(negedge clk);
            if (bus.period_tick === 1'b1) ticks++;
        end
        check("t5 ticks in 30 cycles", 32'(ticks), 32'h3);
        bus.en = 1'b1;
        sync_tick("t5 re-enable");
        period_chk("t5 p1", 3, 3);

        // 6: reset mid-ramp, then load on the boundary cycle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rst pwm", 32'(bus.pwm_out), 32'h0);
        check("t6 rst in_a", 32'(bus.in_a), 32'h0);
        check("t6 rst in_b", 32'(bus.in_b), 32'h0);
        check("t6 rst at_target", 32'(bus.at_target), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("t6 at_target after rst", 32'(bus.at_target), 32'h3);
        sync_tick("t6 align");
        repeat (PERIOD - 1) @(negedge clk);
        do_load(5, 0, 2'b00);
        period_chk("t6 p1", 0, 0);
        period_chk("t6 p2", 3, 0);
        period_chk("t6 p3", 5, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
